// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Constants shared by the UART blocks.
//   - Default geometry of the receive FIFO (entry count and byte width).
//   - Baud-rate generator constants: reference clock, line rate, oversampling
//     factor and the resulting divisor used by the bit-sampling logic.
//   - A helper that sizes the occupancy counter for a given FIFO depth.
// -----------------------------------------------------------------------------
package uart_pkg;

  // Receive FIFO defaults
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_DW    = 8;

  // Baud generation: the receiver samples each bit OVERSAMPLE times, so the
  // divisor counts reference clocks per sample tick.
  localparam int UART_CLK_HZ     = 50_000_000;
  localparam int UART_BAUD_RATE  = 115_200;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_BAUD_DIV   = UART_CLK_HZ / (UART_BAUD_RATE * UART_OVERSAMPLE);
  localparam int UART_BAUD_DIV_W = $clog2(UART_BAUD_DIV + 1);

  // Occupancy counter width: one extra bit so the value DEPTH itself fits.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
//   DEPTH x DW register array backing the UART receive FIFO.
//   Synchronous write port, asynchronous (combinational) read port so the
//   FIFO head can be presented with no read latency. The array is not reset;
//   validity of entries is tracked by the FIFO pointers and count.
//
// Ports
//   i_clk    in   1    write clock
//   i_we     in   1    write enable
//   i_waddr  in   AW   write address
//   i_wdata  in   DW   write data
//   i_raddr  in   AW   read address
//   o_rdata  out  DW   data stored at i_raddr
// -----------------------------------------------------------------------------
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int DW    = UART_FIFO_DW,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   First-word-fall-through receive FIFO sitting behind a UART receiver.
//   A byte is captured on the rising edge of the receiver's valid strobe, so a
//   strobe held high for several cycles stores the byte once. When the FIFO is
//   full and nothing is popped, an incoming byte is dropped and a sticky
//   overrun flag is raised. An interrupt is requested when the fill level
//   reaches a programmable threshold or when an overrun is pending.
//
// Ports
//   clk_i       in   1      clock, all state updates on the rising edge
//   rstn_i      in   1      asynchronous active-low reset
//   rx_data_i   in   DW     received byte
//   rx_valid_i  in   1      byte-valid strobe (edge-detected)
//   rd_en_i     in   1      pop request
//   rd_data_o   out  DW     head-of-queue byte, 0 when empty
//   empty_o     out  1      count_o == 0
//   full_o      out  1      count_o == DEPTH
//   count_o     out  CW     number of stored bytes
//   thresh_i    in   CW     interrupt fill threshold (0 acts as 1, >DEPTH as DEPTH)
//   overrun_o   out  1      sticky byte-lost flag
//   ovr_clr_i   in   1      clears overrun_o (a same-cycle new overrun wins)
//   irq_o       out  1      interrupt request
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int DW    = UART_FIFO_DW,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = fifo_cnt_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] rx_data_i,
  input  logic          rx_valid_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o,
  input  logic [CW-1:0] thresh_i,
  output logic          overrun_o,
  input  logic          ovr_clr_i,
  output logic          irq_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovr;
  logic          r_vld_d;

  logic          w_wr_evt;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [DW-1:0] w_mem_rdata;
  logic [CW-1:0] w_thr_clamp;
  logic [CW-1:0] w_thr_eff;

  // Rising edge of the receiver strobe is the only write trigger.
  assign w_wr_evt = rx_valid_i & ~r_vld_d;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == DEPTH_C);

  // A pop on an empty FIFO is silently ignored.
  assign w_pop    = rd_en_i & ~w_empty;

  // On a full FIFO a same-cycle pop frees the slot being written, so the
  // byte is accepted; only a write into a full FIFO without a pop is lost.
  assign w_push   = w_wr_evt & (~w_full | w_pop);
  assign w_drop   = w_wr_evt & w_full & ~w_pop;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_vld_d <= 1'b0;
    end else begin
      r_vld_d <= rx_valid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + ONE_C;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - ONE_C;
      end
    end
  end

  // Set has priority over clear so an overrun in the clearing cycle is kept.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ovr <= 1'b0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
    end else if (ovr_clr_i) begin
      r_ovr <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .i_clk   (clk_i),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (rx_data_i),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  // Threshold of 0 behaves as 1; anything beyond DEPTH behaves as DEPTH.
  assign w_thr_clamp = (thresh_i > DEPTH_C) ? DEPTH_C : thresh_i;
  assign w_thr_eff   = (w_thr_clamp == '0) ? ONE_C : w_thr_clamp;

  // Stale array contents are masked so an empty FIFO always reads as 0.
  assign rd_data_o = w_empty ? '0 : w_mem_rdata;
  assign empty_o   = w_empty;
  assign full_o    = w_full;
  assign count_o   = r_count;
  assign overrun_o = r_ovr;
  assign irq_o     = (r_count >= w_thr_eff) | r_ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed self-checking bench for uart_rx_fifo (DEPTH=16, DW=8).
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic [CW-1:0] thresh;
  logic          overrun;
  logic          ovr_clr;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rd_en_i    (rd_en),
    .rd_data_o  (rd_data),
    .empty_o    (empty),
    .full_o     (full),
    .count_o    (count),
    .thresh_i   (thresh),
    .overrun_o  (overrun),
    .ovr_clr_i  (ovr_clr),
    .irq_o      (irq)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [DW-1:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wr_pop(input logic [DW-1:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    rd_en    = 1'b1;
    tick();
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    tick();
  endtask

  initial begin
    rstn     = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    ovr_clr  = 1'b0;
    thresh   = CW'(8);
    #1;
    chk("rst_count",   count,   0);
    chk("rst_empty",   empty,   1);
    chk("rst_full",    full,    0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_irq",     irq,     0);
    chk("rst_overrun", overrun, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Basic FWFT ordering
    wr_byte(8'h41);
    wr_byte(8'h42);
    wr_byte(8'h43);
    chk("fwft_count3", count,   3);
    chk("fwft_head",   rd_data, 8'h41);
    chk("fwft_nempty", empty,   0);
    chk("fwft_irq_lo", irq,     0);
    chk("pop1", rd_data, 8'h41); pop();
    chk("pop2", rd_data, 8'h42); pop();
    chk("pop3", rd_data, 8'h43); pop();
    chk("drain_empty", empty,   1);
    chk("drain_data",  rd_data, 0);

    // Pop on empty is ignored
    pop();
    chk("pop_empty_count", count, 0);
    chk("pop_empty_flag",  empty, 1);

    // Held strobe stores once
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (5) tick();
    rx_valid = 1'b0;
    tick();
    chk("held_count", count,   1);
    chk("held_data",  rd_data, 8'h55);
    pop();
    chk("held_drain", count, 0);

    // Interrupt threshold
    thresh = CW'(4);
    wr_byte(8'h01);
    wr_byte(8'h02);
    wr_byte(8'h03);
    #1;
    chk("thr4_cnt3_irq", irq, 0);
    wr_byte(8'h04);
    chk("thr4_cnt4_irq", irq, 1);
    pop(); pop(); pop();
    chk("thr_cnt1", count, 1);
    thresh = CW'(0);
    #1;
    chk("thr0_cnt1_irq", irq, 1);
    thresh = CW'(31);
    #1;
    chk("thr31_cnt1_irq", irq, 0);
    pop();
    thresh = CW'(0);
    #1;
    chk("thr0_cnt0_irq", irq, 0);

    // Fill, overrun and clear
    thresh = CW'(31);
    for (int i = 0; i < DEPTH; i++) wr_byte(8'(16 + i));
    chk("fill_full",  full,    1);
    chk("fill_count", count,   16);
    chk("thr31_full_irq", irq, 1);
    chk("fill_ovr0",  overrun, 0);
    wr_byte(8'h99);
    chk("ovr_set",    overrun, 1);
    chk("ovr_full",   full,    1);
    chk("ovr_count",  count,   16);
    chk("ovr_irq",    irq,     1);
    chk("ovr_head",   rd_data, 8'h10);
    // Clear coinciding with a new overrun keeps the flag
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    ovr_clr  = 1'b1;
    tick();
    rx_valid = 1'b0;
    ovr_clr  = 1'b0;
    tick();
    chk("ovr_set_wins", overrun, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Full FIFO: write and pop together
    wr_pop(8'hAA);
    chk("full_wp_count", count,   16);
    chk("full_wp_ovr",   overrun, 0);
    chk("full_wp_full",  full,    1);
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] exp_b;
      exp_b = (i < DEPTH - 1) ? 8'(8'h11 + i) : 8'hAA;
      chk($sformatf("full_drain_%0d", i), rd_data, exp_b);
      pop();
    end
    chk("full_drain_empty", empty, 1);

    // Write and pop together on empty: only the write happens
    wr_pop(8'h3C);
    chk("empty_wp_count", count,   1);
    chk("empty_wp_data",  rd_data, 8'h3C);
    // Write and pop together at partial fill
    wr_byte(8'h3D);
    wr_pop(8'h3E);
    chk("mid_wp_count", count,   2);
    chk("mid_wp_head",  rd_data, 8'h3D);

    // Asynchronous reset between edges
    wr_byte(8'hC1);
    wr_byte(8'hC2);
    wr_byte(8'hC3);
    chk("pre_rst_count", count, 5);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_count", count,   0);
    chk("arst_empty", empty,   1);
    chk("arst_data",  rd_data, 0);
    chk("arst_irq",   irq,     0);
    tick();
    rstn = 1'b1;
    tick();
    wr_byte(8'h5A);
    chk("post_rst_count", count,   1);
    chk("post_rst_data",  rd_data, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
